alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Sequences and shares the single 4-bit add/sub unit (en, mux_sel, a, b -> c; sel=1 gives a-b, sel=0 gives a+b, en=0 gives 4'b1111) between two requesters.
- Round-robin arbitration, operand latching and one-cycle issue to the unit.
- Registered result capture with a valid/ack response handshake.
- Sits between the board-level input logic (switch/button requesters) and the shared arithmetic unit; its result feeds the LED display path.

Parameters:
- W, 4, operand/result width; must match the shared unit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  2  per-requester request; held high until the matching gnt bit is seen.
- sel0  in  1  requester 0 op: 0=add, 1=sub.
- a0  in  W  requester 0 operand a.
- b0  in  W  requester 0 operand b.
- sel1  in  1  requester 1 op: 0=add, 1=sub.
- a1  in  W  requester 1 operand a.
- b1  in  W  requester 1 operand b.
- gnt  out  2  one-hot, one-cycle grant pulse.
- busy  out  1  high whenever state != IDLE.
- res_valid  out  1  result available.
- res_id  out  1  owner of the result.
- res_data  out  W  captured result.
- res_ack  in  1  consumer accepts result.
- alu_en  out  1  to shared unit en.
- alu_sel  out  1  to shared unit mux_sel.
- alu_a  out  W  to shared unit input_a.
- alu_b  out  W  to shared unit input_b.
- alu_c  in  W  from shared unit output_c.
- cnt0  out  8  requester 0 grant count (optional feature).
- cnt1  out  8  requester 1 grant count (optional feature).

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last=1, so requester 0 wins the first tie.
  - gnt=0, busy=0, res_valid=0, res_id=0, res_data=0.
  - Latched sel/a/b=0, cnt0=cnt1=0.
- Reset mid-operation: any in-flight op or unacked result is discarded; no grant or valid appears in the cycle after reset.
- FSM states are IDLE, ISSUE, RESP. All outputs are registered or decoded from state only; there is no combinational path from req to gnt.
- IDLE:
  - If req==2'b00, stay in IDLE.
  - If exactly one req bit is set, select it.
  - If req==2'b11, select ~last.
  - On a selection: latch that requester's sel/a/b, set owner, set gnt[owner]=1 for the next cycle only, and move to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_en=1, alu_sel/alu_a/alu_b driven from the latched registers.
  - At the end of the cycle: res_data<=alu_c, res_id<=owner, res_valid<=1, last<=owner, then go to RESP.
- RESP:
  - Hold res_valid/res_id/res_data stable until res_ack=1.
  - On ack: res_valid<=0 and go to IDLE.
  - req is ignored while in RESP.
- Outside ISSUE: alu_en=0 and alu_sel/alu_a/alu_b=0. The unit then outputs 4'b1111, which is never captured.
- Latency and throughput:
  - req sampled in IDLE at cycle N -> gnt and ISSUE at N+1 -> res_valid at N+2.
  - With ack at N+2: IDLE at N+3, next ISSUE at N+4 at the earliest.
- Arithmetic is modulo 2^W in the shared unit; no carry or borrow is reported. Example: 4'hF+4'h1=4'h0, 4'h2-4'h5=4'hD.
- Boundary cases:
  - A requester dropping req before its gnt is legal; it simply is not selected.
  - res_ack asserted while res_valid=0 is ignored.
  - res_ack held high continuously allows back-to-back operation at 3 cycles per op.
  - Both requesters held high alternate grants 0,1,0,1...

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - cnt0/cnt1 increment on each gnt pulse of their requester.
  - Saturate at 8'hFF.
  - Cleared by rst.
- Undefined: cnt0/cnt1 tied to 8'h00 and the counter logic is absent. Ports exist in both builds.

Test Plan:
- Reset then idle: rst 2 cycles, req=00 for 10 cycles -> gnt=00, busy=0, res_valid=0, alu_en=0 throughout.
- Single add: req=01, a0=3, b0=4, sel0=0, res_ack=0 -> gnt=01 one cycle later, alu_en=1 for 1 cycle with alu_a=3, alu_b=4, alu_sel=0, then res_valid=1, res_id=0, res_data=7 held until ack.
- Subtract wrap on requester 1: a1=2, b1=5, sel1=1 -> res_data=4'hD, res_id=1. Add wrap: a1=F, b1=1, sel1=0 -> res_data=0.
- Contention: req=11 held, res_ack=1 -> grants in order 0,1,0,1, gnt pulses 3 cycles apart, each res_id matches the grant.
- Reset in RESP: assert rst while res_valid=1 -> next cycle res_valid=0, state IDLE, then req=11 -> requester 0 granted first.
- ARB_STATS_EN defined: 300 grants to requester 0 -> cnt0=8'hFF, cnt1=0. Undefined: both counters read 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one W-bit add/sub unit between two requesters. A round-robin choice
// is made in IDLE, the winner's operands are latched and issued to the unit
// for exactly one cycle, and the unit's output is captured into a result
// register that is held until the consumer acknowledges it.
//
// Optional build macro ARB_STATS_EN: when defined, cnt0/cnt1 count grant
// pulses per requester (saturating at 8'hFF). When undefined they read 0.
module alu_share_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic         sel0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         sel1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         res_valid,
  output logic         res_id,
  output logic [W-1:0] res_data,
  input  logic         res_ack,
  output logic         alu_en,
  output logic         alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_c,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state;
  logic           last;
  logic           owner;
  logic           lat_sel;
  logic [W-1:0]   lat_a;
  logic [W-1:0]   lat_b;
  logic           pick_vld;
  logic           pick;

  // Round-robin choice: a lone request wins; on a tie the one not served last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 1'b0;
    case (req)
      2'b01:   begin pick_vld = 1'b1; pick = 1'b0;  end
      2'b10:   begin pick_vld = 1'b1; pick = 1'b1;  end
      2'b11:   begin pick_vld = 1'b1; pick = ~last; end
      default: begin pick_vld = 1'b0; pick = 1'b0;  end
    endcase
  end

  // Sequencer: grant and latch in IDLE, one issue cycle, then hold the result until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_sel   <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
      gnt       <= 2'b00;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
    end else begin
      gnt <= 2'b00;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner   <= pick;
            lat_sel <= pick ? sel1 : sel0;
            lat_a   <= pick ? a1 : a0;
            lat_b   <= pick ? b1 : b0;
            gnt     <= pick ? 2'b10 : 2'b01;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          res_data  <= alu_c;
          res_id    <= owner;
          res_valid <= 1'b1;
          last      <= owner;
          state     <= RESP;
        end
        RESP: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Unit drive is decoded from state: operands only reach the unit during ISSUE.
  always_comb begin
    busy    = (state != IDLE);
    alu_en  = (state == ISSUE);
    alu_sel = alu_en ? lat_sel : 1'b0;
    alu_a   = alu_en ? lat_a : '0;
    alu_b   = alu_en ? lat_b : '0;
  end

`ifdef ARB_STATS_EN
  // Saturating per-requester grant counters, advanced on each grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= 8'h00;
      cnt1 <= 8'h00;
    end else begin
      if (gnt[0] && (cnt0 != 8'hFF)) cnt0 <= cnt0 + 8'd1;
      if (gnt[1] && (cnt1 != 8'hFF)) cnt1 <= cnt1 + 8'd1;
    end
  end
`else
  assign cnt0 = 8'h00;
  assign cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Scoreboarded bench: the stimulus side predicts each grant (owner, operands,
// result) from round-robin rules and pushes it; a separate monitor pops and
// compares when a grant pulse or a new result appears.
module tb_alu_share_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic         sel0 = 1'b0, sel1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt;
  logic         busy, res_valid, res_id, res_ack = 1'b0;
  logic [W-1:0] res_data;
  logic         alu_en, alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic [7:0]   cnt0, cnt1;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .sel0(sel0), .a0(a0), .b0(b0), .sel1(sel1), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_ack(res_ack),
    .alu_en(alu_en), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Shared add/sub unit
  assign alu_c = alu_en ? (alu_sel ? alu_a - alu_b : alu_a + alu_b) : 4'hF;

  always #5 clk = ~clk;

  typedef struct { int id; int sel; int a; int b; int c; } txn_t;
  txn_t gq[$];
  txn_t rq[$];

  int checks = 0, passed = 0;
  int cyc = 0;
  int last_m = 1;
  int c0_m = 0, c1_m = 0;
  bit flush = 1'b1;
  int ack_mode = 0;    // 0 random, 1 always, 2 never
  bit checked = 1'b0;
  int held_id, held_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: grant/issue and result checks plus the consumer's ack
  always @(negedge clk) begin
    txn_t e;
    if (flush) begin
      checked = 1'b0;
      res_ack = 1'b0;
    end else begin
      if (gnt != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
        else begin
          e = gq.pop_front();
          chk("gnt_owner", int'(gnt), 1 << e.id);
          chk("issue_en", int'(alu_en), 1);
          chk("issue_sel", int'(alu_sel), e.sel);
          chk("issue_a", int'(alu_a), e.a);
          chk("issue_b", int'(alu_b), e.b);
          rq.push_back(e);
        end
      end else begin
        chk("alu_quiet", int'({alu_en, alu_sel, alu_a, alu_b}), 0);
      end
      if (res_valid) begin
        if (!checked) begin
          if (rq.size() == 0) chk("res_unexpected", int'(res_valid), 0);
          else begin
            e = rq.pop_front();
            chk("res_id", int'(res_id), e.id);
            chk("res_data", int'(res_data), e.c);
          end
          held_id = int'(res_id);
          held_data = int'(res_data);
          checked = 1'b1;
        end else begin
          chk("res_stable", int'({res_id, res_data}), (held_id << W) | held_data);
        end
      end
      case (ack_mode)
        0: res_ack = 1'($urandom_range(0, 1));
        1: res_ack = 1'b1;
        default: res_ack = 1'b0;
      endcase
      if (res_valid && res_ack) checked = 1'b0;
    end
  end

  // Predict a grant for request pattern pat and queue its expected result.
  task automatic predict(input int pat);
    txn_t t;
    if (pat == 3) t.id = (last_m == 1) ? 0 : 1;
    else t.id = (pat == 2) ? 1 : 0;
    last_m = t.id;
    t.sel = (t.id == 1) ? int'(sel1) : int'(sel0);
    t.a   = (t.id == 1) ? int'(a1) : int'(a0);
    t.b   = (t.id == 1) ? int'(b1) : int'(b0);
    t.c   = ((t.sel == 1) ? (t.a - t.b) : (t.a + t.b)) & ((1 << W) - 1);
    if (t.id == 0) c0_m = (c0_m < 255) ? c0_m + 1 : 255;
    else c1_m = (c1_m < 255) ? c1_m + 1 : 255;
    gq.push_back(t);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin ok = 1'b1; break; end
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    flush = 1'b1;
    rst = 1'b1;
    req = 2'b00;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    gq.delete();
    rq.delete();
    last_m = 1;
    c0_m = 0;
    c1_m = 0;
    chk("rst_state", int'({gnt, busy, res_valid, res_id, res_data, alu_en}), 0);
    chk("rst_cnt", int'({cnt0, cnt1}), 0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_txn(input int pat, input logic s0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic s1, input logic [W-1:0] x1, input logic [W-1:0] y1);
    bit ok;
    sel0 = s0; a0 = x0; b0 = y0; sel1 = s1; a1 = x1; b1 = y1;
    predict(pat);
    req = 2'(pat);
    wait_gnt(ok);
    req = 2'b00;
  endtask

  task automatic contention(input int n);
    bit ok;
    int prev;
    prev = -1;
    req = 2'b11;
    for (int i = 0; i < n; i++) begin
      predict(3);
      wait_gnt(ok);
      if (ok && prev >= 0) chk("contention_gap", cyc - prev, 3);
      prev = cyc;
    end
    req = 2'b00;
  endtask

  task automatic drain;
    for (int i = 0; i < 60; i++) begin
      if (gq.size() == 0 && rq.size() == 0 && !res_valid && !busy) break;
      @(negedge clk);
    end
    chk("drain_empty", gq.size() + rq.size() + int'(busy), 0);
  endtask

  initial begin
    bit ok;
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 10; i++)
      chk("idle_quiet", int'({gnt, busy, res_valid, alu_en}), 0);
    repeat (10) begin
      chk("idle_quiet", int'({gnt, busy, res_valid, alu_en}), 0);
      @(negedge clk);
    end

    // directed: add on 0, sub wrap on 1, add wrap on 1
    ack_mode = 0;
    do_txn(1, 1'b0, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    do_txn(2, 1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd5);
    do_txn(2, 1'b0, 4'd0, 4'd0, 1'b0, 4'hF, 4'd1);

    // randomized patterns, operands and ack timing
    for (int i = 0; i < 60; i++)
      do_txn($urandom_range(1, 3), 1'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), 4'($urandom), 4'($urandom));
    drain();

    // contention with continuous ack
    ack_mode = 1;
    sel0 = 1'b0; a0 = 4'd9; b0 = 4'd8; sel1 = 1'b1; a1 = 4'd1; b1 = 4'd3;
    contention(8);
    drain();

    // reset while a result waits for ack
    ack_mode = 2;
    sel0 = 1'b1; a0 = 4'd6; b0 = 4'd2;
    predict(1);
    req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    chk("resp_reached", int'(res_valid), 1);
    do_reset(1);
    ack_mode = 1;
    contention(4);
    drain();

    // stats: 300 grants to requester 0
    do_reset(2);
    sel0 = 1'b0; a0 = 4'd5; b0 = 4'd5;
    req = 2'b01;
    for (int i = 0; i < 300; i++) begin
      predict(1);
      wait_gnt(ok);
      if (!ok) break;
    end
    req = 2'b00;
    drain();
    repeat (2) @(negedge clk);
`ifdef ARB_STATS_EN
    chk("cnt0", int'(cnt0), c0_m);
    chk("cnt1", int'(cnt1), c1_m);
`else
    chk("cnt0", int'(cnt0), 0);
    chk("cnt1", int'(cnt1), 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
